// File: rtl/lb_slot_desc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lb_slot_desc_ctrl_pkg
//   Shared definitions for the per-core free-slot descriptor manager:
//   - pool_state_e : per-core pool FSM encoding (IDLE / DRAIN / LOAD)
//   - max_int      : elaboration-time maximum, used for the tag field width
//   - cnt_width    : bits needed to hold the values 0..n (free counts, tags,
//                    drain counter)
// -----------------------------------------------------------------------------
package lb_slot_desc_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_LOAD  = 2'd2
   } pool_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/lb_slot_desc_ctrl_pool.sv
// -----------------------------------------------------------------------------
// lb_slot_desc_ctrl_pool
//   One core's free-slot pool: bitmap of free slots (bit i = tag i+1), free
//   count, IDLE/DRAIN/LOAD FSM with drain counter, sticky bad-release flag and
//   a lowest-set-bit encoder that produces the next tag to hand out.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   i_pop        pop request already qualified by core selection
//   i_rel_valid  release aimed at this core
//   i_rel_tag    released tag (1..SLOT_COUNT legal)
//   i_flush      flush pulse: empty the pool and restart the drain
//   i_err_clear  clear pulse for the sticky error
//   o_tag        lowest free tag, 0 when the bitmap is empty
//   o_count      registered free count
//   o_valid      count != 0 and not busy
//   o_busy       flush drain / reload in progress
//   o_err        sticky bad-release flag
// -----------------------------------------------------------------------------
module lb_slot_desc_ctrl_pool
   import lb_slot_desc_ctrl_pkg::*;
#(
   parameter int SLOT_COUNT  = 32,
   parameter int FLUSH_DRAIN = 16,
   parameter int SLOT_WIDTH  = 6,
   parameter int TAG_WIDTH   = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_pop,
   input  logic                  i_rel_valid,
   input  logic [TAG_WIDTH-1:0]  i_rel_tag,
   input  logic                  i_flush,
   input  logic                  i_err_clear,
   output logic [SLOT_WIDTH-1:0] o_tag,
   output logic [SLOT_WIDTH-1:0] o_count,
   output logic                  o_valid,
   output logic                  o_busy,
   output logic                  o_err
);

   localparam int DRAIN_W = cnt_width(FLUSH_DRAIN);

   pool_state_e             r_state;
   logic [DRAIN_W-1:0]      r_drain;
   logic [SLOT_COUNT-1:0]   r_bitmap;
   logic [SLOT_WIDTH-1:0]   r_count;
   logic                    r_err;

   pool_state_e             w_state_nxt;
   logic [DRAIN_W-1:0]      w_drain_nxt;
   logic [SLOT_COUNT-1:0]   w_bitmap_nxt;
   logic [SLOT_WIDTH-1:0]   w_count_nxt;
   logic                    w_err_nxt;

   logic [SLOT_WIDTH-1:0]   w_tag;
   logic [SLOT_COUNT-1:0]   w_pop_mask;
   logic [SLOT_COUNT-1:0]   w_rel_mask;
   logic                    w_idle;
   logic                    w_valid;
   logic                    w_rel_in_range;
   logic                    w_rel_hit;
   logic                    w_rel_bad;
   logic                    w_rel_ok;
   logic                    w_pop_ok;

   // Lowest-set-bit encoder: scanning downward leaves the lowest index last.
   always_comb begin
      w_tag = '0;
      for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
         if (r_bitmap[i]) w_tag = SLOT_WIDTH'(i + 1);
      end
   end

   // Two's-complement trick isolates the lowest set bit (0 when empty).
   assign w_pop_mask     = r_bitmap & (~r_bitmap + SLOT_COUNT'(1));

   assign w_idle         = (r_state == ST_IDLE);
   assign w_valid        = w_idle && (r_count != '0);
   assign w_pop_ok       = i_pop && w_valid;

   assign w_rel_in_range = (i_rel_tag != '0) && (i_rel_tag <= TAG_WIDTH'(SLOT_COUNT));
   assign w_rel_mask     = w_rel_in_range ? (SLOT_COUNT'(1) << (i_rel_tag - TAG_WIDTH'(1)))
                                          : '0;
   // Releases are only considered while IDLE; during DRAIN/LOAD they vanish
   // without flagging. The duplicate test uses the bitmap as sampled, so
   // releasing the slot popped in this same cycle counts as bad.
   assign w_rel_hit      = i_rel_valid && w_idle;
   assign w_rel_bad      = w_rel_hit && (!w_rel_in_range || ((r_bitmap & w_rel_mask) != '0));
   assign w_rel_ok       = w_rel_hit && !w_rel_bad;

   always_comb begin
      w_state_nxt  = r_state;
      w_drain_nxt  = r_drain;
      w_bitmap_nxt = r_bitmap;
      w_count_nxt  = r_count;
      w_err_nxt    = r_err & ~i_err_clear;

      if (i_flush) begin
         // Flush overrides any pop/release in the same cycle and restarts the
         // drain from whatever state the pool is in.
         w_state_nxt  = ST_DRAIN;
         w_drain_nxt  = DRAIN_W'(FLUSH_DRAIN);
         w_bitmap_nxt = '0;
         w_count_nxt  = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop_ok) w_bitmap_nxt = w_bitmap_nxt & ~w_pop_mask;
               if (w_rel_ok) w_bitmap_nxt = w_bitmap_nxt | w_rel_mask;
               // Pop needs count>0 and release needs a clear bit, so this
               // can neither underflow nor exceed SLOT_COUNT.
               w_count_nxt = r_count + SLOT_WIDTH'(w_rel_ok) - SLOT_WIDTH'(w_pop_ok);
               if (w_rel_bad) w_err_nxt = 1'b1;
            end
            ST_DRAIN: begin
               w_drain_nxt = r_drain - DRAIN_W'(1);
               if (r_drain <= DRAIN_W'(1)) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
               w_state_nxt  = ST_IDLE;
               w_bitmap_nxt = '1;
               w_count_nxt  = SLOT_WIDTH'(SLOT_COUNT);
               w_err_nxt    = 1'b0;
            end
            default: begin
               // Unreachable encoding: recover through a full re-init.
               w_state_nxt  = ST_DRAIN;
               w_drain_nxt  = DRAIN_W'(FLUSH_DRAIN);
               w_bitmap_nxt = '0;
               w_count_nxt  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_DRAIN;
         r_drain  <= DRAIN_W'(FLUSH_DRAIN);
         r_bitmap <= '0;
         r_count  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_drain  <= w_drain_nxt;
         r_bitmap <= w_bitmap_nxt;
         r_count  <= w_count_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign o_tag   = w_tag;
   assign o_count = r_count;
   assign o_valid = w_valid;
   assign o_busy  = !w_idle;
   assign o_err   = r_err;

endmodule

// File: rtl/lb_slot_desc_ctrl.sv
// -----------------------------------------------------------------------------
// lb_slot_desc_ctrl
//   Per-core free-slot descriptor manager between the core slot-release path
//   and the load-balancer port logic. One pool per core; the top decodes the
//   pop (by selected core) and release (by core field of the descriptor) and
//   muxes the descriptor of the selected core.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_selected_core   core chosen by the LB
//   i_desc_pop        consume the lowest free slot of the selected core
//   o_desc_data       {selected_core, tag}; 0 while in reset
//   i_s_rel_data      released descriptor {core, tag}
//   i_s_rel_valid     release valid
//   o_s_rel_ready     1 once out of reset (releases accepted every cycle)
//   i_slots_flush     per-core flush/re-init pulse
//   i_ins_err_clear   per-core sticky-error clear pulse
//   o_slot_counts     packed per-core free counts
//   o_slot_valids     per-core count!=0 && !busy
//   o_slot_busys      per-core drain/reload in progress
//   o_slot_ins_errs   per-core sticky bad-release flag
// -----------------------------------------------------------------------------
module lb_slot_desc_ctrl
   import lb_slot_desc_ctrl_pkg::*;
#(
   parameter int  CORE_COUNT    = 8,
   parameter int  SLOT_COUNT    = 32,
   parameter int  FLUSH_DRAIN   = 16,
   localparam int SLOT_WIDTH    = cnt_width(SLOT_COUNT),
   localparam int CORE_ID_WIDTH = max_int($clog2(CORE_COUNT), 1),
   localparam int TAG_WIDTH     = max_int(SLOT_WIDTH, 5),
   localparam int ID_TAG_WIDTH  = CORE_ID_WIDTH + TAG_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [CORE_ID_WIDTH-1:0]         i_selected_core,
   input  logic                             i_desc_pop,
   output logic [ID_TAG_WIDTH-1:0]          o_desc_data,
   input  logic [ID_TAG_WIDTH-1:0]          i_s_rel_data,
   input  logic                             i_s_rel_valid,
   output logic                             o_s_rel_ready,
   input  logic [CORE_COUNT-1:0]            i_slots_flush,
   input  logic [CORE_COUNT-1:0]            i_ins_err_clear,
   output logic [CORE_COUNT*SLOT_WIDTH-1:0] o_slot_counts,
   output logic [CORE_COUNT-1:0]            o_slot_valids,
   output logic [CORE_COUNT-1:0]            o_slot_busys,
   output logic [CORE_COUNT-1:0]            o_slot_ins_errs
);

   logic                     r_out_en;
   logic [CORE_ID_WIDTH-1:0] w_rel_core;
   logic [TAG_WIDTH-1:0]     w_rel_tag;
   logic [SLOT_WIDTH-1:0]    w_tags [CORE_COUNT];
   logic [SLOT_WIDTH-1:0]    w_tag_sel;

   // Holds desc_data and s_rel_ready at 0 for as long as reset is applied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_out_en <= 1'b0;
      else        r_out_en <= 1'b1;
   end

   assign w_rel_core = i_s_rel_data[ID_TAG_WIDTH-1:TAG_WIDTH];
   assign w_rel_tag  = i_s_rel_data[TAG_WIDTH-1:0];

   // A core index with no matching pool (c >= CORE_COUNT) hits no instance,
   // so such releases are dropped without touching any state.
   for (genvar c = 0; c < CORE_COUNT; c++) begin : g_pool
      lb_slot_desc_ctrl_pool #(
         .SLOT_COUNT  (SLOT_COUNT),
         .FLUSH_DRAIN (FLUSH_DRAIN),
         .SLOT_WIDTH  (SLOT_WIDTH),
         .TAG_WIDTH   (TAG_WIDTH)
      ) u_pool (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_pop       (i_desc_pop && (i_selected_core == CORE_ID_WIDTH'(c))),
         .i_rel_valid (i_s_rel_valid && (w_rel_core == CORE_ID_WIDTH'(c))),
         .i_rel_tag   (w_rel_tag),
         .i_flush     (i_slots_flush[c]),
         .i_err_clear (i_ins_err_clear[c]),
         .o_tag       (w_tags[c]),
         .o_count     (o_slot_counts[c*SLOT_WIDTH +: SLOT_WIDTH]),
         .o_valid     (o_slot_valids[c]),
         .o_busy      (o_slot_busys[c]),
         .o_err       (o_slot_ins_errs[c])
      );
   end

   always_comb begin
      w_tag_sel = '0;
      for (int c = 0; c < CORE_COUNT; c++) begin
         if (i_selected_core == CORE_ID_WIDTH'(c)) w_tag_sel = w_tags[c];
      end
   end

   assign o_desc_data   = r_out_en ? {i_selected_core, TAG_WIDTH'(w_tag_sel)} : '0;
   assign o_s_rel_ready = r_out_en;

endmodule

// File: tb/tb_lb_slot_desc_ctrl.sv
module tb_lb_slot_desc_ctrl;

   localparam int CC = 8;
   localparam int SC = 32;
   localparam int DR = 16;
   localparam int SW = 6;
   localparam int TW = 6;
   localparam int CW = 3;
   localparam int IW = CW + TW;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [CW-1:0]   i_selected_core;
   logic            i_desc_pop;
   logic [IW-1:0]   o_desc_data;
   logic [IW-1:0]   i_s_rel_data;
   logic            i_s_rel_valid;
   logic            o_s_rel_ready;
   logic [CC-1:0]   i_slots_flush;
   logic [CC-1:0]   i_ins_err_clear;
   logic [CC*SW-1:0] o_slot_counts;
   logic [CC-1:0]   o_slot_valids;
   logic [CC-1:0]   o_slot_busys;
   logic [CC-1:0]   o_slot_ins_errs;

   always #5 clk = ~clk;

   lb_slot_desc_ctrl #(.CORE_COUNT(CC), .SLOT_COUNT(SC), .FLUSH_DRAIN(DR)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_selected_core (i_selected_core),
      .i_desc_pop      (i_desc_pop),
      .o_desc_data     (o_desc_data),
      .i_s_rel_data    (i_s_rel_data),
      .i_s_rel_valid   (i_s_rel_valid),
      .o_s_rel_ready   (o_s_rel_ready),
      .i_slots_flush   (i_slots_flush),
      .i_ins_err_clear (i_ins_err_clear),
      .o_slot_counts   (o_slot_counts),
      .o_slot_valids   (o_slot_valids),
      .o_slot_busys    (o_slot_busys),
      .o_slot_ins_errs (o_slot_ins_errs)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference model: each core is a set of free tags plus a "cycles left
   // busy" number; a flush makes the core busy for FLUSH_DRAIN+1 cycles and
   // it comes back with every tag free.
   bit m_free [CC][SC+1];
   int m_busy [CC];
   bit m_err  [CC];

   function automatic int m_low(input int c);
      for (int t = 1; t <= SC; t++) if (m_free[c][t]) return t;
      return 0;
   endfunction

   function automatic int m_cnt(input int c);
      int n = 0;
      for (int t = 1; t <= SC; t++) n += int'(m_free[c][t]);
      return n;
   endfunction

   task automatic m_step(input int sel, input int pop, input int rv, input int rcore,
                         input int rtag, input logic [CC-1:0] fl, input logic [CC-1:0] cl);
      for (int c = 0; c < CC; c++) begin
         int low = m_low(c);
         m_err[c] = m_err[c] & !cl[c];
         if (fl[c]) begin
            m_busy[c] = DR + 1;
            for (int t = 1; t <= SC; t++) m_free[c][t] = 1'b0;
         end else if (m_busy[c] > 0) begin
            m_busy[c]--;
            if (m_busy[c] == 0) begin
               for (int t = 1; t <= SC; t++) m_free[c][t] = 1'b1;
               m_err[c] = 1'b0;
            end
         end else begin
            bit bad = 1'b0;
            bit add = 1'b0;
            if (rv != 0 && rcore == c) begin
               if (rtag < 1 || rtag > SC) bad = 1'b1;
               else if (m_free[c][rtag]) bad = 1'b1;
               else add = 1'b1;
            end
            if (pop != 0 && sel == c && low != 0) m_free[c][low] = 1'b0;
            if (add) m_free[c][rtag] = 1'b1;
            if (bad) m_err[c] = 1'b1;
         end
      end
   endtask

   int last_tag;

   // One clock: drive at negedge, check the combinational descriptor, take
   // the edge, advance the model, then check all registered outputs.
   task automatic cyc(input int sel, input int pop, input int rv, input int rcore,
                      input int rtag, input logic [CC-1:0] fl, input logic [CC-1:0] cl);
      logic [CC-1:0] ev, eb, ee;
      @(negedge clk);
      i_selected_core = sel[CW-1:0];
      i_desc_pop      = (pop != 0);
      i_s_rel_valid   = (rv != 0);
      i_s_rel_data    = {rcore[CW-1:0], rtag[TW-1:0]};
      i_slots_flush   = fl;
      i_ins_err_clear = cl;
      #1;
      last_tag = int'(o_desc_data[TW-1:0]);
      chk("desc_core", int'(o_desc_data[IW-1:TW]), sel);
      chk("desc_tag", last_tag, m_low(sel));
      @(posedge clk);
      m_step(sel, pop, rv, rcore, rtag, fl, cl);
      #1;
      for (int c = 0; c < CC; c++) begin
         chk($sformatf("count[%0d]", c), int'(o_slot_counts[c*SW +: SW]), m_cnt(c));
         ev[c] = (m_cnt(c) != 0) && (m_busy[c] == 0);
         eb[c] = (m_busy[c] != 0);
         ee[c] = m_err[c];
      end
      chk("valids", int'(o_slot_valids), int'(ev));
      chk("busys", int'(o_slot_busys), int'(eb));
      chk("errs", int'(o_slot_ins_errs), int'(ee));
      chk("ready", int'(o_s_rel_ready), 1);
   endtask

   function automatic int cnt_of(input int c);
      return int'(o_slot_counts[c*SW +: SW]);
   endfunction

   typedef struct {
      int            sel;
      int            pop;
      int            rv;
      int            rcore;
      int            rtag;
      logic [CC-1:0] clr;
      int            chk_c;
      int            etag;
      int            ecnt;
      int            eerr;
   } vec_t;

   vec_t tbl [17];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{3, 1, 0, 0, 0,  8'h00, 3, 1, 31, 0};
      tbl[1]  = '{3, 1, 0, 0, 0,  8'h00, 3, 2, 30, 0};
      tbl[2]  = '{3, 1, 0, 0, 0,  8'h00, 3, 3, 29, 0};
      tbl[3]  = '{3, 0, 1, 3, 2,  8'h00, 3, 4, 30, 0};
      tbl[4]  = '{3, 1, 0, 0, 0,  8'h00, 3, 2, 29, 0};
      tbl[5]  = '{3, 0, 1, 3, 2,  8'h00, 3, 4, 30, 0};
      tbl[6]  = '{3, 0, 1, 3, 2,  8'h00, 3, 2, 30, 1};
      tbl[7]  = '{3, 0, 0, 0, 0,  8'h08, 3, 2, 30, 0};
      tbl[8]  = '{2, 0, 1, 2, 0,  8'h00, 2, 1, 32, 1};
      tbl[9]  = '{2, 0, 0, 0, 0,  8'h04, 2, 1, 32, 0};
      tbl[10] = '{2, 0, 1, 2, 33, 8'h00, 2, 1, 32, 1};
      tbl[11] = '{2, 0, 1, 2, 33, 8'h04, 2, 1, 32, 1};
      tbl[12] = '{2, 0, 0, 0, 0,  8'h04, 2, 1, 32, 0};
      tbl[13] = '{3, 1, 1, 3, 2,  8'h00, 3, 2, 29, 1};
      tbl[14] = '{3, 0, 0, 0, 0,  8'h08, 3, 4, 29, 0};
      tbl[15] = '{3, 1, 1, 3, 1,  8'h00, 3, 4, 29, 0};
      tbl[16] = '{3, 1, 0, 0, 0,  8'h00, 3, 1, 28, 0};

      for (int c = 0; c < CC; c++) begin
         m_busy[c] = DR + 1;
         m_err[c]  = 1'b0;
         for (int t = 0; t <= SC; t++) m_free[c][t] = 1'b0;
      end

      // Reset values
      rst_n           = 1'b0;
      i_selected_core = 3'd3;
      i_desc_pop      = 1'b0;
      i_s_rel_data    = '0;
      i_s_rel_valid   = 1'b0;
      i_slots_flush   = '0;
      i_ins_err_clear = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_desc", int'(o_desc_data), 0);
      chk("rst_ready", int'(o_s_rel_ready), 0);
      chk("rst_busys", int'(o_slot_busys), 8'hFF);
      chk("rst_valids", int'(o_slot_valids), 0);
      chk("rst_errs", int'(o_slot_ins_errs), 0);
      chk("rst_count0", cnt_of(0), 0);
      i_selected_core = 3'd0;
      #1;
      rst_n = 1'b1;

      // Drain after reset, then every pool reloads
      repeat (DR + 1) cyc(0, 0, 0, 0, 0, 8'h00, 8'h00);
      for (int c = 0; c < CC; c++) chk($sformatf("init_count[%0d]", c), cnt_of(c), SC);
      chk("init_valids", int'(o_slot_valids), 8'hFF);
      chk("init_busys", int'(o_slot_busys), 0);
      chk("init_ready", int'(o_s_rel_ready), 1);

      // Directed vectors: pops, releases, duplicates, bad tags, error clear
      for (int i = 0; i < 17; i++) begin
         cyc(tbl[i].sel, tbl[i].pop, tbl[i].rv, tbl[i].rcore, tbl[i].rtag, 8'h00, tbl[i].clr);
         chk($sformatf("tbl%0d_tag", i), last_tag, tbl[i].etag);
         chk($sformatf("tbl%0d_count", i), cnt_of(tbl[i].chk_c), tbl[i].ecnt);
         chk($sformatf("tbl%0d_err", i), int'(o_slot_ins_errs[tbl[i].chk_c]), tbl[i].eerr);
      end

      // Core 5 down to one slot, pop+release same cycle, then empty pop
      for (int i = 0; i < SC - 1; i++) cyc(5, 1, 0, 0, 0, 8'h00, 8'h00);
      chk("c5_last_tag", last_tag, SC - 1);
      chk("c5_count1", cnt_of(5), 1);
      cyc(5, 1, 1, 5, 7, 8'h00, 8'h00);
      chk("c5_poprel_tag", last_tag, SC);
      chk("c5_poprel_count", cnt_of(5), 1);
      chk("c5_poprel_err", int'(o_slot_ins_errs[5]), 0);
      cyc(5, 1, 0, 0, 0, 8'h00, 8'h00);
      chk("c5_pop7_tag", last_tag, 7);
      chk("c5_count0", cnt_of(5), 0);
      chk("c5_valid0", int'(o_slot_valids[5]), 0);
      cyc(5, 1, 0, 0, 0, 8'h00, 8'h00);
      chk("c5_empty_tag", last_tag, 0);
      chk("c5_empty_count", cnt_of(5), 0);
      chk("c5_empty_err", int'(o_slot_ins_errs[5]), 0);

      // Flush core 1 with a pending error and a same-cycle pop
      cyc(0, 0, 1, 1, 0, 8'h00, 8'h00);
      chk("c1_err_set", int'(o_slot_ins_errs[1]), 1);
      cyc(1, 1, 0, 0, 0, 8'h02, 8'h00);
      chk("c1_flush_tag", last_tag, 1);
      chk("c1_flush_busy", int'(o_slot_busys[1]), 1);
      chk("c1_flush_count", cnt_of(1), 0);
      cyc(0, 0, 1, 1, 5, 8'h00, 8'h00);
      chk("c1_rel_dropped", cnt_of(1), 0);
      chk("c1_rel_noerr", int'(o_slot_ins_errs[1]), 1);
      repeat (DR - 2) cyc(0, 1, 0, 0, 0, 8'h00, 8'h00);
      chk("c1_still_busy", int'(o_slot_busys[1]), 1);
      repeat (2) cyc(0, 0, 0, 0, 0, 8'h00, 8'h00);
      chk("c1_reload_count", cnt_of(1), SC);
      chk("c1_reload_busy", int'(o_slot_busys[1]), 0);
      chk("c1_reload_err", int'(o_slot_ins_errs[1]), 0);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         int sel, pop, rv, rcore, rtag, r;
         logic [CC-1:0] fl, cl;
         sel   = int'($urandom_range(0, CC - 1));
         pop   = ($urandom_range(0, 9) < 6) ? 1 : 0;
         rv    = ($urandom_range(0, 9) < 5) ? 1 : 0;
         rcore = int'($urandom_range(0, CC - 1));
         r     = int'($urandom_range(0, 19));
         if (r == 0)      rtag = 0;
         else if (r == 1) rtag = int'($urandom_range(SC + 1, 63));
         else             rtag = int'($urandom_range(1, SC));
         fl = '0;
         if ($urandom_range(0, 79) == 0) fl[$urandom_range(0, CC - 1)] = 1'b1;
         cl = ($urandom_range(0, 19) == 0) ? CC'($urandom) : '0;
         cyc(sel, pop, rv, rcore, rtag, fl, cl);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
